// File: rtl/hazard_pkg.sv
// Shared definitions for the Tuse/Tnew hazard scoreboard: default widths,
// the "never read" Tuse marker, the scoreboard entry layout and the per
// instruction-class timing values used by the address/timing decoder.
package hazard_pkg;

    localparam int unsigned AW_DEF = 5;
    localparam int unsigned TW_DEF = 3;

    // All-ones Tuse means the operand is never read; never stored as a Tnew.
    localparam logic [TW_DEF-1:0] TNONE = {TW_DEF{1'b1}};

    typedef struct packed {
        logic [AW_DEF-1:0] waddr;
        logic [TW_DEF-1:0] tnew;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{waddr: '0, tnew: '0};

    // Tnew: cycles after E entry until the result exists in the pipe.
    localparam logic [TW_DEF-1:0] TNEW_ALU  = 3'd1;
    localparam logic [TW_DEF-1:0] TNEW_LOAD = 3'd2;
    localparam logic [TW_DEF-1:0] TNEW_LUI  = 3'd0;
    localparam logic [TW_DEF-1:0] TNEW_JAL  = 3'd1;

    // Tuse: cycles after D until the operand is consumed.
    localparam logic [TW_DEF-1:0] TUSE_BRANCH   = 3'd0;
    localparam logic [TW_DEF-1:0] TUSE_JR       = 3'd0;
    localparam logic [TW_DEF-1:0] TUSE_ALU      = 3'd1;
    localparam logic [TW_DEF-1:0] TUSE_STORE_RT = 3'd2;

endpackage

// File: rtl/hazard_if.sv
// Decode-side descriptor bus and scoreboard results. The master is the
// decode stage; the slave is the hazard scoreboard.
interface hazard_if
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned TW     = TW_DEF,
    parameter int unsigned SW     = 2
);

    logic                   d_valid;
    logic [NUM_RD*AW-1:0]   d_raddr;
    logic [NUM_RD*TW-1:0]   d_tuse;
    logic [AW-1:0]          d_waddr;
    logic [TW-1:0]          d_tnew;
    logic                   flush;
    logic                   stall;
    logic [NUM_RD*SW-1:0]   fwd_sel;
    logic [DEPTH*AW-1:0]    stage_waddr;
    logic [DEPTH*TW-1:0]    stage_tnew;

    modport master (
        output d_valid, d_raddr, d_tuse, d_waddr, d_tnew, flush,
        input  stall, fwd_sel, stage_waddr, stage_tnew
    );

    modport slave (
        input  d_valid, d_raddr, d_tuse, d_waddr, d_tnew, flush,
        output stall, fwd_sel, stage_waddr, stage_tnew
    );

endinterface

// File: rtl/hazard_port_check.sv
// One decode read port checked against every tracked stage. The youngest
// matching writer decides both the stall request and the forward select.
module hazard_port_check
    import hazard_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned TW    = TW_DEF,
    parameter int unsigned SW    = 2
) (
    input  logic [AW-1:0]       raddr,
    input  logic [TW-1:0]       tuse,
    input  logic [DEPTH*AW-1:0] stage_waddr,
    input  logic [DEPTH*TW-1:0] stage_tnew,
    output logic                hazard,
    output logic [SW-1:0]       fwd_sel
);

    localparam logic [TW-1:0] TNONE_W = {TW{1'b1}};

    logic          active;
    logic          hit;
    logic [TW-1:0] hit_tnew;
    logic [SW-1:0] hit_sel;

    // $0 and unread operands never cause a hazard; bubbles carry waddr 0
    // so they can never match an active port.
    assign active = (raddr != '0) && (tuse != TNONE_W);

    // Priority match: scan oldest to youngest so the youngest writer wins.
    always_comb begin
        hit      = 1'b0;
        hit_tnew = '0;
        hit_sel  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (stage_waddr[i*AW +: AW] == raddr) begin
                hit      = 1'b1;
                hit_tnew = stage_tnew[i*TW +: TW];
                hit_sel  = SW'(i + 1);
            end
        end
    end

    // Stall when the value arrives later than it is needed; forward only a
    // value that already exists (tnew 0).
    always_comb begin
        hazard  = 1'b0;
        fwd_sel = '0;
        if (active && hit) begin
            hazard = (hit_tnew > tuse);
            if (hit_tnew == '0) begin
                fwd_sel = hit_sel;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard unit: a shifting scoreboard of in-flight writers (E, M, W)
// with per-cycle Tnew countdown, producing the D-stage stall and per-port
// forward selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned TW     = TW_DEF,
    parameter int unsigned SW     = 2
) (
    input logic     clk,
    input logic     rst_n,
    hazard_if.slave bus
);

    localparam logic [TW-1:0] TNONE_W = {TW{1'b1}};

    logic [AW-1:0]        waddr_q [DEPTH];
    logic [AW-1:0]        waddr_d [DEPTH];
    logic [TW-1:0]        tnew_q  [DEPTH];
    logic [TW-1:0]        tnew_d  [DEPTH];
    logic [DEPTH*AW-1:0]  stage_waddr;
    logic [DEPTH*TW-1:0]  stage_tnew;
    logic [NUM_RD-1:0]    hazard;
    logic [NUM_RD*SW-1:0] fwd_sel;
    logic                 stall;
    logic                 insert;
    logic [TW-1:0]        d_tnew_clamped;

    // Flatten the scoreboard for the port checkers and the downstream muxes.
    always_comb begin
        stage_waddr = '0;
        stage_tnew  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            stage_waddr[i*AW +: AW] = waddr_q[i];
            stage_tnew[i*TW +: TW]  = tnew_q[i];
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_port
        hazard_port_check #(
            .DEPTH (DEPTH),
            .AW    (AW),
            .TW    (TW),
            .SW    (SW)
        ) u_check (
            .raddr       (bus.d_raddr[r*AW +: AW]),
            .tuse        (bus.d_tuse[r*TW +: TW]),
            .stage_waddr (stage_waddr),
            .stage_tnew  (stage_tnew),
            .hazard      (hazard[r]),
            .fwd_sel     (fwd_sel[r*SW +: SW])
        );
    end

    // A bubble in D can never stall, whatever its descriptor fields say.
    assign stall  = bus.d_valid & (|hazard);
    assign insert = bus.d_valid & ~stall & ~bus.flush;

    // TNONE is reserved for Tuse; clamp it so a stored Tnew still counts down.
    assign d_tnew_clamped = (bus.d_tnew == TNONE_W) ? TNONE_W - 1'b1 : bus.d_tnew;

    // Next scoreboard: E takes D or a bubble, later stages shift with a
    // saturating Tnew decrement; W's old entry drops off the end.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            waddr_d[i] = '0;
            tnew_d[i]  = '0;
        end
        if (insert) begin
            waddr_d[0] = bus.d_waddr;
            tnew_d[0]  = d_tnew_clamped;
        end
        for (int i = 1; i < DEPTH; i++) begin
            waddr_d[i] = waddr_q[i-1];
            tnew_d[i]  = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - 1'b1;
        end
    end

    // Scoreboard state; reset empties every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= '0;
                tnew_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= waddr_d[i];
                tnew_q[i]  <= tnew_d[i];
            end
        end
    end

    assign bus.stall       = stall;
    assign bus.fwd_sel     = fwd_sel;
    assign bus.stage_waddr = stage_waddr;
    assign bus.stage_tnew  = stage_tnew;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: MIPS instruction pairs with
// hand-computed stall / forward / scoreboard expectations.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    hazard_if #(.NUM_RD(2), .DEPTH(3), .AW(5), .TW(3), .SW(2)) bus ();

    hazard_scoreboard #(
        .NUM_RD (2),
        .DEPTH  (3),
        .AW     (5),
        .TW     (3),
        .SW     (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] R0  = 5'd0;
    localparam logic [4:0] R1  = 5'd1;
    localparam logic [4:0] R2  = 5'd2;
    localparam logic [4:0] R8  = 5'd8;
    localparam logic [4:0] R9  = 5'd9;
    localparam logic [4:0] R10 = 5'd10;
    localparam logic [4:0] R29 = 5'd29;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one D-stage descriptor and let the combinational outputs settle.
    task automatic drive(input logic v, input logic [4:0] ra0, input logic [2:0] tu0,
                         input logic [4:0] ra1, input logic [2:0] tu1,
                         input logic [4:0] wa, input logic [2:0] tn, input logic fl);
        bus.d_valid = v;
        bus.d_raddr = {ra1, ra0};
        bus.d_tuse  = {tu1, tu0};
        bus.d_waddr = wa;
        bus.d_tnew  = tn;
        bus.flush   = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, R0, TNONE, R0, TNONE, R0, 3'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    function automatic int unsigned fwd(input int p);
        return int'(bus.fwd_sel[p*2 +: 2]);
    endfunction

    function automatic int unsigned swa(input int s);
        return int'(bus.stage_waddr[s*5 +: 5]);
    endfunction

    function automatic int unsigned stn(input int s);
        return int'(bus.stage_tnew[s*3 +: 3]);
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        idle();

        // 1: reset, then three idle cycles
        repeat (2) tick();
        check("rst_stall", bus.stall, 0);
        check("rst_waddr", bus.stage_waddr, 0);
        check("rst_tnew", bus.stage_tnew, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("idle_stall", bus.stall, 0);
            check("idle_fwd", bus.fwd_sel, 0);
            check("idle_waddr", bus.stage_waddr, 0);
            tick();
        end

        // 2: addu $8 then beq $8,$9
        drive(1'b1, R1, TUSE_ALU, R2, TUSE_ALU, R8, TNEW_ALU, 1'b0);
        check("addu_nostall", bus.stall, 0);
        tick();
        drive(1'b1, R8, TUSE_BRANCH, R9, TUSE_BRANCH, R0, 3'd0, 1'b0);
        check("beq_stall", bus.stall, 1);
        check("beq_fwd0_wait", fwd(0), 0);
        check("e_waddr", swa(0), 8);
        check("e_tnew", stn(0), 1);
        tick();
        check("beq_release", bus.stall, 0);
        check("beq_fwd0_m", fwd(0), 2);
        check("beq_fwd1", fwd(1), 0);
        check("bubble_in_e", swa(0), 0);
        check("m_tnew_dec", stn(1), 0);
        tick();
        drain();

        // 3a: lw $8 then beq $8 -> two stalls, then forward from W
        drive(1'b1, R29, TUSE_ALU, R0, TNONE, R8, TNEW_LOAD, 1'b0);
        tick();
        drive(1'b1, R8, TUSE_BRANCH, R9, TUSE_BRANCH, R0, 3'd0, 1'b0);
        check("lw_beq_stall1", bus.stall, 1);
        tick();
        check("lw_beq_stall2", bus.stall, 1);
        check("lw_m_tnew", stn(1), 1);
        tick();
        check("lw_beq_go", bus.stall, 0);
        check("lw_beq_fwd_w", fwd(0), 3);
        tick();
        drain();

        // 3b: lw $8 then addu rs=$8 -> one stall
        drive(1'b1, R29, TUSE_ALU, R0, TNONE, R8, TNEW_LOAD, 1'b0);
        tick();
        drive(1'b1, R8, TUSE_ALU, R9, TUSE_ALU, R10, TNEW_ALU, 1'b0);
        check("lw_addu_stall", bus.stall, 1);
        tick();
        check("lw_addu_go", bus.stall, 0);
        check("lw_addu_fwd_late", fwd(0), 0);
        tick();
        drain();

        // 4a: lui $8 then addu rs=$8 -> forward from E
        drive(1'b1, R0, TNONE, R0, TNONE, R8, TNEW_LUI, 1'b0);
        tick();
        drive(1'b1, R8, TUSE_ALU, R9, TUSE_ALU, R10, TNEW_ALU, 1'b0);
        check("lui_nostall", bus.stall, 0);
        check("lui_fwd_e", fwd(0), 1);
        tick();
        drain();

        // 4b: writer to $0 then reader of $0
        drive(1'b1, R1, TUSE_ALU, R0, TNONE, R0, TNEW_ALU, 1'b0);
        tick();
        drive(1'b1, R0, TUSE_BRANCH, R0, TUSE_BRANCH, R0, 3'd0, 1'b0);
        check("r0_nostall", bus.stall, 0);
        check("r0_fwd", bus.fwd_sel, 0);
        tick();
        drain();

        // 5: addu $8 (older) and lw $8 (younger) -> youngest wins
        drive(1'b1, R1, TUSE_ALU, R2, TUSE_ALU, R8, TNEW_ALU, 1'b0);
        tick();
        drive(1'b1, R29, TUSE_ALU, R0, TNONE, R8, TNEW_LOAD, 1'b0);
        check("lw_after_addu_nostall", bus.stall, 0);
        tick();
        drive(1'b1, R8, TUSE_ALU, R9, TUSE_ALU, R10, TNEW_ALU, 1'b0);
        check("young_stall", bus.stall, 1);
        check("young_fwd0", fwd(0), 0);
        check("young_e_tnew", stn(0), 2);
        check("old_m_tnew", stn(1), 0);
        check("old_m_waddr", swa(1), 8);
        tick();
        check("young_m_go", bus.stall, 0);
        check("young_m_fwd", fwd(0), 0);
        check("old_w_tnew_sat", stn(2), 0);
        tick();
        drain();

        // 6a: lw $8 flushed on insertion, then beq $8
        drive(1'b1, R29, TUSE_ALU, R0, TNONE, R8, TNEW_LOAD, 1'b1);
        tick();
        check("flush_bubble", swa(0), 0);
        drive(1'b1, R8, TUSE_BRANCH, R9, TUSE_BRANCH, R0, 3'd0, 1'b0);
        check("flush_nostall", bus.stall, 0);
        tick();
        drain();

        // d_tnew = TNONE is clamped; inactive and invalid readers never stall
        drive(1'b1, R1, TUSE_ALU, R0, TNONE, R10, 3'd7, 1'b0);
        tick();
        check("clamp_e", stn(0), 6);
        drive(1'b1, R10, TNONE, R0, TNONE, R0, 3'd0, 1'b0);
        check("tnone_nostall", bus.stall, 0);
        drive(1'b0, R10, TUSE_BRANCH, R0, TNONE, R0, 3'd0, 1'b0);
        check("invalid_nostall", bus.stall, 0);
        drive(1'b1, R10, TUSE_BRANCH, R0, TNONE, R0, 3'd0, 1'b0);
        check("valid_stall", bus.stall, 1);
        idle();
        tick();
        check("clamp_m", stn(1), 5);
        drain();

        // 6b: reset asserted mid-stall
        drive(1'b1, R29, TUSE_ALU, R0, TNONE, R8, TNEW_LOAD, 1'b0);
        tick();
        drive(1'b1, R8, TUSE_BRANCH, R9, TUSE_BRANCH, R0, 3'd0, 1'b0);
        check("pre_rst_stall", bus.stall, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", bus.stall, 0);
        check("mid_rst_waddr", bus.stage_waddr, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_stall", bus.stall, 0);
        check("post_rst_fwd", bus.fwd_sel, 0);
        tick();
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised Tuse/Tnew hazard unit for the pipelined MIPS core.
- Takes the decode-stage read/write descriptors from the per-instruction address/timing decoder.
- Tracks every in-flight writer past D in a shifting scoreboard with per-cycle Tnew countdown.
- Produces the D-stage stall and forward selects, and exports per-stage writer info for downstream forwarding muxes.

Parameters:
NUM_RD, 2, number of decode read ports (rs, rt, optional third source)
DEPTH, 3, tracked stages past D (index 0=E, 1=M, 2=W)
AW, 5, register address width
TW, 3, Tuse/Tnew width; all-ones (7) = TNONE, meaning "operand never read"
SW, 2, forward-select width; must satisfy 2^SW > DEPTH

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
d_valid  in  1  D-stage instruction valid (0 = bubble)
d_raddr  in  NUM_RD*AW  read addresses, port r at bits [r*AW +: AW]
d_tuse  in  NUM_RD*TW  Tuse per read port
d_waddr  in  AW  destination register (0 = no write)
d_tnew  in  TW  Tnew of D instruction, relative to E entry
flush  in  1  kill the instruction entering E this cycle
stall  out  1  freeze PC/IF-ID, insert bubble into E (combinational)
fwd_sel  out  NUM_RD*SW  per port: 0 = register file, k = stage k-1
stage_waddr  out  DEPTH*AW  destination held at each stage (0 if bubble)
stage_tnew  out  DEPTH*TW  remaining Tnew at each stage

Behaviour:
- Storage: DEPTH entries {waddr, tnew}. A bubble has waddr=0, tnew=0.
- Reset, asynchronous on rst_n=0: all entries become bubbles.
  - Consequently stall=0, fwd_sel=0, stage_waddr=0, stage_tnew=0.
  - Reset asserted mid-stall discards all in-flight state. The first cycle after release sees an empty scoreboard.
- Per clock edge:
  - Stage i, for i≥1, loads stage i-1 with tnew decremented, saturating at 0.
  - The stage DEPTH-1 entry is discarded.
  - Stage 0 loads {d_waddr, d_tnew} when d_valid & ~stall & ~flush. Otherwise it loads a bubble.
  - stall and flush together produce a single bubble, with no extra effect.
  - Entries past stage 0 always advance; the unit never stalls E/M/W.
- Per read port r (combinational), a port is inactive when raddr=0 or tuse=TNONE. Inactive ports give fwd_sel=0 and no stall.
  - Match = lowest stage index i with stage_waddr[i]==raddr (youngest writer wins; older matches ignored).
  - With no match: fwd_sel=0.
  - With a match: hazard_r = tnew[i] > tuse_r; fwd_sel = (tnew[i]==0) ? i+1 : 0.
  - tnew>0 without hazard yields fwd_sel=0. Downstream stages pick the value up from stage_waddr/stage_tnew.
- stall = d_valid & OR(hazard_r). d_valid=0 forces stall=0.
- TW arithmetic is unsigned. TNONE is never stored as tnew: d_tnew=7 is clamped to 6 on insertion.
- stage_waddr/stage_tnew are direct register outputs with zero latency.

Decomposition:
- Shared package hazard_pkg:
  - TNONE constant
  - AW/TW defaults
  - scoreboard entry typedef {waddr, tnew}
  - bubble constant
  - Tuse/Tnew values per instruction class: ALU Tnew=1, load Tnew=2, lui Tnew=0, jal Tnew=1, branch/jr Tuse=0, store-rt Tuse=2.
- Sub-module hazard_port_check: one read port against all DEPTH entries. It performs the priority match and outputs {hazard, fwd_sel}. It is instantiated NUM_RD times via generate.
- The top level holds the shift register and the stall OR-reduce.

Test Plan:
1. Hold rst_n=0, then release with d_valid=0 for 3 cycles -> stall=0, fwd_sel=0, stage_waddr=0 throughout.
2. addu $8 (d_tnew=1), then beq $8,$9 (tuse 0,0) -> stall=1 for exactly 1 cycle. Next cycle $8 is in M with tnew 0: stall=0, fwd_sel port0=2.
3. lw $8 (tnew 2), then beq rs=$8 -> stall for 2 cycles. Then fwd_sel=3 (W). Same lw followed by addu rs=$8 (tuse 1) -> 1-cycle stall.
4. lui $8 (tnew 0), then addu rs=$8 -> no stall, fwd_sel port0=1. A writer to $0 followed by a reader of $0 -> no stall, fwd_sel=0.
5. addu $8 in M (tnew 0) and lw $8 in E (tnew 2), then addu rs=$8 -> youngest wins: stall=1, and M's ready value is ignored.
6. lw $8 with flush=1 on its insertion edge, then beq $8 -> stage 0 is a bubble, no stall. Also assert rst_n low mid-stall -> stall drops to 0 immediately.
